// File: rtl/axi_lite_pkg.sv
// ==== axi_lite_pkg : AXI4-Lite register slave shared types | rev 1.0 ====
`default_nettype none

package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam int         ADDR_LSB    = 2;
  localparam int         DATA_W      = 32;
  localparam int         STRB_W      = DATA_W / 8;

  typedef enum logic [1:0] {
    W_IDLE   = 2'd0,
    W_HAVE_A = 2'd1,
    W_HAVE_D = 2'd2,
    W_RESP   = 2'd3
  } wr_state_e;

  typedef enum logic [0:0] {
    R_IDLE = 1'b0,
    R_RESP = 1'b1
  } rd_state_e;

endpackage

`default_nettype wire

// File: rtl/axi_lite_reg_bank.sv
// ==== axi_lite_reg_bank : byte-strobed register file with pulse and read mux | rev 1.0 ====
`default_nettype none

module axi_lite_reg_bank
  import axi_lite_pkg::*;
#(
  parameter int NUM_REGS = 4,
  parameter int IDX_W    = 3
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       wr_en_i,
  input  logic [IDX_W-1:0]           wr_idx_i,
  input  logic [DATA_W-1:0]          wr_data_i,
  input  logic [STRB_W-1:0]          wr_strb_i,
  input  logic [IDX_W-1:0]           rd_idx_i,
  output logic                       wr_in_range_o,
  output logic                       rd_in_range_o,
  output logic [DATA_W-1:0]          rd_data_o,
  output logic [NUM_REGS*DATA_W-1:0] regs_o,
  output logic [NUM_REGS-1:0]        wr_pulse_o
);

  // One extra bit so NUM_REGS == 2**IDX_W still compares correctly.
  localparam logic [IDX_W:0] C_NUM_REGS = (IDX_W+1)'(NUM_REGS);

  assign wr_in_range_o = ({1'b0, wr_idx_i} < C_NUM_REGS);
  assign rd_in_range_o = ({1'b0, rd_idx_i} < C_NUM_REGS);

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    logic              hit;
    logic [DATA_W-1:0] reg_q;
    logic              pulse_q;

    assign hit = wr_en_i && wr_in_range_o && (wr_idx_i == IDX_W'(i));

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        reg_q   <= '0;
        pulse_q <= 1'b0;
      end else begin
        pulse_q <= hit;
        for (int b = 0; b < STRB_W; b++) begin
          if (hit && wr_strb_i[b]) reg_q[8*b +: 8] <= wr_data_i[8*b +: 8];
        end
      end
    end

    assign regs_o[DATA_W*i +: DATA_W] = reg_q;
    assign wr_pulse_o[i]              = pulse_q;
  end

  always_comb begin
    rd_data_o = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_idx_i == IDX_W'(i)) rd_data_o = regs_o[DATA_W*i +: DATA_W];
    end
  end

endmodule

`default_nettype wire

// File: rtl/axi4_lite_reg_slave.sv
// ==== axi4_lite_reg_slave : AXI4-Lite slave exposing NUM_REGS 32-bit registers | rev 1.0 ====
`default_nettype none

module axi4_lite_reg_slave
  import axi_lite_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5,
  parameter int NUM_REGS           = 4
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [NUM_REGS*32-1:0]          reg_out,
  output logic [NUM_REGS-1:0]             wr_pulse
);

  localparam int IDX_W = C_S_AXI_ADDR_WIDTH - ADDR_LSB;

  wr_state_e         wstate_q, wstate_d;
  rd_state_e         rstate_q, rstate_d;
  logic              ready_en_q;
  logic [IDX_W-1:0]  awidx_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] wstrb_q;
  logic [1:0]        bresp_q;
  logic [DATA_W-1:0] rdata_q;
  logic [1:0]        rresp_q;

  logic              aw_hs, w_hs, ar_hs, commit;
  logic [IDX_W-1:0]  commit_idx;
  logic [DATA_W-1:0] commit_data;
  logic [STRB_W-1:0] commit_strb;
  logic              wr_in_range, rd_in_range;
  logic [DATA_W-1:0] rd_data;
  logic              unused_bits;

  assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[ADDR_LSB-1:0],
                         S_AXI_ARADDR[ADDR_LSB-1:0]};

  assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID  && S_AXI_WREADY;
  assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

  // Readies stay low until the first edge after reset release.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      ready_en_q <= 1'b0;
      wstate_q   <= W_IDLE;
      rstate_q   <= R_IDLE;
    end else begin
      ready_en_q <= 1'b1;
      wstate_q   <= wstate_d;
      rstate_q   <= rstate_d;
    end
  end

  always_comb begin
    wstate_d = wstate_q;
    unique case (wstate_q)
      W_IDLE: begin
        if (aw_hs && w_hs) wstate_d = W_RESP;
        else if (aw_hs)    wstate_d = W_HAVE_A;
        else if (w_hs)     wstate_d = W_HAVE_D;
      end
      W_HAVE_A: if (w_hs)         wstate_d = W_RESP;
      W_HAVE_D: if (aw_hs)        wstate_d = W_RESP;
      W_RESP:   if (S_AXI_BREADY) wstate_d = W_IDLE;
      default:                    wstate_d = W_IDLE;
    endcase
  end

  always_comb begin
    S_AXI_AWREADY = ready_en_q && ((wstate_q == W_IDLE) || (wstate_q == W_HAVE_D));
    S_AXI_WREADY  = ready_en_q && ((wstate_q == W_IDLE) || (wstate_q == W_HAVE_A));
    S_AXI_BVALID  = (wstate_q == W_RESP);
  end

  // Whichever half arrived earlier comes from the holding registers.
  always_comb begin
    commit      = 1'b0;
    commit_idx  = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB];
    commit_data = S_AXI_WDATA;
    commit_strb = S_AXI_WSTRB;
    unique case (wstate_q)
      W_IDLE:   commit = aw_hs && w_hs;
      W_HAVE_A: begin
        commit     = w_hs;
        commit_idx = awidx_q;
      end
      W_HAVE_D: begin
        commit      = aw_hs;
        commit_data = wdata_q;
        commit_strb = wstrb_q;
      end
      default:  commit = 1'b0;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      awidx_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      bresp_q <= RESP_OKAY;
    end else begin
      if (aw_hs) awidx_q <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB];
      if (w_hs) begin
        wdata_q <= S_AXI_WDATA;
        wstrb_q <= S_AXI_WSTRB;
      end
      if (commit) bresp_q <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
    end
  end

  always_comb begin
    rstate_d = rstate_q;
    unique case (rstate_q)
      R_IDLE:  if (ar_hs)        rstate_d = R_RESP;
      R_RESP:  if (S_AXI_RREADY) rstate_d = R_IDLE;
      default:                   rstate_d = R_IDLE;
    endcase
  end

  always_comb begin
    S_AXI_ARREADY = ready_en_q && (rstate_q == R_IDLE);
    S_AXI_RVALID  = (rstate_q == R_RESP);
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
    end else if (ar_hs) begin
      rdata_q <= rd_in_range ? rd_data : '0;
      rresp_q <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
    end
  end

  assign S_AXI_BRESP = bresp_q;
  assign S_AXI_RDATA = rdata_q;
  assign S_AXI_RRESP = rresp_q;

  axi_lite_reg_bank #(
    .NUM_REGS (NUM_REGS),
    .IDX_W    (IDX_W)
  ) u_bank (
    .clk_i         (S_AXI_ACLK),
    .rst_ni        (S_AXI_ARESETN),
    .wr_en_i       (commit),
    .wr_idx_i      (commit_idx),
    .wr_data_i     (commit_data),
    .wr_strb_i     (commit_strb),
    .rd_idx_i      (S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB]),
    .wr_in_range_o (wr_in_range),
    .rd_in_range_o (rd_in_range),
    .rd_data_o     (rd_data),
    .regs_o        (reg_out),
    .wr_pulse_o    (wr_pulse)
  );

endmodule

`default_nettype wire

// File: tb/tb_axi4_lite_reg_slave.sv
// ==== tb_axi4_lite_reg_slave : directed vector bench for axi4_lite_reg_slave | rev 1.0 ====
`default_nettype none

module tb_axi4_lite_reg_slave;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [4:0]   awaddr = '0;
  logic [2:0]   awprot = '0;
  logic         awvalid = 1'b0;
  logic         awready;
  logic [31:0]  wdata = '0;
  logic [3:0]   wstrb = '0;
  logic         wvalid = 1'b0;
  logic         wready;
  logic [1:0]   bresp;
  logic         bvalid;
  logic         bready = 1'b0;
  logic [4:0]   araddr = '0;
  logic [2:0]   arprot = '0;
  logic         arvalid = 1'b0;
  logic         arready;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         rvalid;
  logic         rready = 1'b0;
  logic [127:0] reg_out;
  logic [3:0]   wr_pulse;

  int n_cmp = 0;
  int n_fail = 0;
  int pcnt [4] = '{0, 0, 0, 0};

  always #5 clk = ~clk;

  axi4_lite_reg_slave #(
    .C_S_AXI_DATA_WIDTH (32),
    .C_S_AXI_ADDR_WIDTH (5),
    .NUM_REGS           (4)
  ) dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWPROT  (awprot),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   (wstrb),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BRESP   (bresp),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARPROT  (arprot),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready),
    .reg_out       (reg_out),
    .wr_pulse      (wr_pulse)
  );

  always @(negedge clk) begin
    for (int j = 0; j < 4; j++) if (wr_pulse[j] === 1'b1) pcnt[j]++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] pulse_snap();
    logic [31:0] s;
    for (int j = 0; j < 4; j++) s[8*j +: 8] = 8'(pcnt[j]);
    return s;
  endfunction

  // Called on a falling edge with no write in flight; returns on a falling edge.
  task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [1:0] resp);
    int t;
    awaddr = a; wdata = d; wstrb = s;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    t = 0;
    while (!(awready && wready) && t < 20) begin @(negedge clk); t++; end
    chk("wr_ready_wait", 1'(t < 20), 1'b1);
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    chk("bvalid_latency", bvalid, 1'b1);
    resp = bresp;
    @(negedge clk);
    chk("bvalid_clear", bvalid, 1'b0);
  endtask

  task automatic do_read(input logic [4:0] a, output logic [31:0] d, output logic [1:0] resp);
    int t;
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    t = 0;
    while (!arready && t < 20) begin @(negedge clk); t++; end
    chk("ar_ready_wait", 1'(t < 20), 1'b1);
    @(negedge clk);
    arvalid = 1'b0;
    chk("rvalid_latency", rvalid, 1'b1);
    d = rdata; resp = rresp;
    @(negedge clk);
    chk("rvalid_clear", rvalid, 1'b0);
  endtask

  typedef struct {
    bit          wr;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
    logic [31:0] rdata;
    int          pidx;
  } vec_t;

  vec_t vecs [17];

  initial begin
    logic [1:0]  r;
    logic [31:0] d;
    logic [31:0] p0;
    logic [31:0] exp_p;
    logic [31:0] held;
    bit          ok;

    vecs[0]  = '{1'b1, 5'h00, 32'h0101FFFF, 4'hF, 2'b00, 32'h0, 0};
    vecs[1]  = '{1'b1, 5'h04, 32'hABCD0001, 4'hF, 2'b00, 32'h0, 1};
    vecs[2]  = '{1'b1, 5'h08, 32'hDEAD0011, 4'hF, 2'b00, 32'h0, 2};
    vecs[3]  = '{1'b1, 5'h0C, 32'hBEEF0011, 4'hF, 2'b00, 32'h0, 3};
    vecs[4]  = '{1'b0, 5'h00, 32'h0, 4'h0, 2'b00, 32'h0101FFFF, -1};
    vecs[5]  = '{1'b0, 5'h04, 32'h0, 4'h0, 2'b00, 32'hABCD0001, -1};
    vecs[6]  = '{1'b0, 5'h08, 32'h0, 4'h0, 2'b00, 32'hDEAD0011, -1};
    vecs[7]  = '{1'b0, 5'h0C, 32'h0, 4'h0, 2'b00, 32'hBEEF0011, -1};
    vecs[8]  = '{1'b1, 5'h00, 32'hFFFFFFFF, 4'hF, 2'b00, 32'h0, 0};
    vecs[9]  = '{1'b1, 5'h00, 32'h00000000, 4'h5, 2'b00, 32'h0, 0};
    vecs[10] = '{1'b0, 5'h00, 32'h0, 4'h0, 2'b00, 32'hFF00FF00, -1};
    vecs[11] = '{1'b1, 5'h10, 32'hCAFEBABE, 4'hF, 2'b10, 32'h0, -1};
    vecs[12] = '{1'b0, 5'h10, 32'h0, 4'h0, 2'b10, 32'h00000000, -1};
    vecs[13] = '{1'b1, 5'h1C, 32'h12345678, 4'hF, 2'b10, 32'h0, -1};
    vecs[14] = '{1'b0, 5'h1C, 32'h0, 4'h0, 2'b10, 32'h00000000, -1};
    vecs[15] = '{1'b0, 5'h04, 32'h0, 4'h0, 2'b00, 32'hABCD0001, -1};
    vecs[16] = '{1'b0, 5'h0C, 32'h0, 4'h0, 2'b00, 32'hBEEF0011, -1};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_valid_ready", {awready, wready, arready, bvalid, rvalid}, 5'b0);
    chk("rst_resp_data", {bresp, rresp, rdata}, 36'h0);
    chk("rst_regs", reg_out, 128'h0);
    chk("rst_pulse", wr_pulse, 4'h0);
    rst_n = 1'b1;
    #1 chk("ready_before_edge", {awready, wready, arready}, 3'b000);
    @(negedge clk);
    chk("ready_after_edge", {awready, wready, arready}, 3'b111);

    // Table-driven vectors
    for (int i = 0; i < 17; i++) begin
      if (vecs[i].wr) begin
        p0 = pulse_snap();
        do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, r);
        chk($sformatf("v%0d_bresp", i), r, vecs[i].resp);
        #1;
        exp_p = p0;
        if (vecs[i].pidx >= 0) exp_p[8*vecs[i].pidx +: 8] = p0[8*vecs[i].pidx +: 8] + 8'd1;
        chk($sformatf("v%0d_pulse", i), pulse_snap(), exp_p);
        @(negedge clk);
      end else begin
        do_read(vecs[i].addr, d, r);
        chk($sformatf("v%0d_rresp", i), r, vecs[i].resp);
        chk($sformatf("v%0d_rdata", i), d, vecs[i].rdata);
      end
    end
    chk("reg_out_after_table", reg_out, {32'hBEEF0011, 32'hDEAD0011, 32'hABCD0001, 32'hFF00FF00});

    // AW three cycles ahead of W
    p0 = pulse_snap();
    awaddr = 5'h04; awvalid = 1'b1; bready = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    chk("have_a_readies", {awready, wready}, 2'b01);
    repeat (2) @(negedge clk);
    chk("have_a_no_b", bvalid, 1'b0);
    wdata = 32'h12345678; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge clk);
    wvalid = 1'b0;
    chk("aw_first_bvalid", {bvalid, bresp}, 3'b100);
    @(negedge clk);
    #1;
    exp_p = p0; exp_p[15:8] = p0[15:8] + 8'd1;
    chk("aw_first_pulse", pulse_snap(), exp_p);
    do_read(5'h04, d, r);
    chk("aw_first_readback", {r, d}, {2'b00, 32'h12345678});

    // W three cycles ahead of AW
    p0 = pulse_snap();
    wdata = 32'h5A5A1234; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge clk);
    wvalid = 1'b0;
    chk("have_d_readies", {awready, wready}, 2'b10);
    repeat (2) @(negedge clk);
    chk("have_d_no_b", bvalid, 1'b0);
    awaddr = 5'h04; awvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    chk("w_first_bvalid", {bvalid, bresp}, 3'b100);
    @(negedge clk);
    #1;
    exp_p = p0; exp_p[15:8] = p0[15:8] + 8'd1;
    chk("w_first_pulse", pulse_snap(), exp_p);
    do_read(5'h04, d, r);
    chk("w_first_readback", {r, d}, {2'b00, 32'h5A5A1234});

    // B backpressure
    bready = 1'b0;
    awaddr = 5'h0C; wdata = 32'h11223344; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    ok = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (!(bvalid === 1'b1 && bresp === 2'b00 && awready === 1'b0 && wready === 1'b0)) ok = 1'b0;
      @(negedge clk);
    end
    chk("b_hold_stable", ok, 1'b1);
    chk("b_still_valid", bvalid, 1'b1);
    bready = 1'b1;
    @(negedge clk);
    chk("b_complete", {bvalid, awready, wready}, 3'b011);

    // R backpressure
    rready = 1'b0;
    araddr = 5'h0C; arvalid = 1'b1;
    @(negedge clk);
    arvalid = 1'b0;
    held = rdata;
    chk("r_hold_data", {rresp, held}, {2'b00, 32'h11223344});
    ok = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (!(rvalid === 1'b1 && rresp === 2'b00 && rdata === held && arready === 1'b0)) ok = 1'b0;
      @(negedge clk);
    end
    chk("r_hold_stable", ok, 1'b1);
    rready = 1'b1;
    @(negedge clk);
    chk("r_complete", {rvalid, arready}, 2'b01);

    // Reset while a write response is pending
    bready = 1'b0;
    awaddr = 5'h00; wdata = 32'h00000077; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    chk("pre_reset_bvalid", bvalid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_bvalid_drop", {bvalid, awready, wready, arready}, 4'b0);
    chk("async_regs_clear", reg_out, 128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    bready = 1'b1;
    #1 chk("post_rst_ready_low", {awready, wready, arready}, 3'b000);
    @(negedge clk);
    ok = 1'b1;
    for (int k = 0; k < 4; k++) begin
      do_read(5'(4 * k), d, r);
      if (!(d === 32'h0 && r === 2'b00)) ok = 1'b0;
    end
    chk("post_rst_regs_zero", ok, 1'b1);
    do_write(5'h00, 32'hABCD0001, 4'hF, r);
    chk("post_rst_bresp", r, 2'b00);
    @(negedge clk);
    do_read(5'h00, d, r);
    chk("post_rst_readback", {r, d}, {2'b00, 32'hABCD0001});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
